cgra_cfg_sequencer: RTL and testbench
=====================================

// Module: cgra_cfg_sequencer
// PURPOSE
//   Host-side controller for the 4x4 PE array and SPM. Accepts a stream of configuration words and
//   assembles the host_controller vector: one config buffer per row (LSU + 4 PE insts), plus SPM bank-group config.
//   It then drives the init window and issues a programmed number of run pulses.
//   Sits between the external host/DMA port and the array top, replacing hand-driven init/run sequencing.
// PARAMETERS
//   CFG_W     203  width of one row config buffer ({LSU inst, pe_n..pe_n+3 insts})
//   SPM_W     20   width of SPM/bank-group config word (fifo_sel, en, sel, mode for BG0..BG3)
//   ROWS      4    number of row config buffers
//   INIT_CYC  3    cycles init is held high after load
//   CNT_W     16   width of run pulse counter
//   GAP_W     8    width of inter-pulse gap counter
// PORTS
//   clk              in   1                  clock, all state on rising edge
//   rst              in   1                  asynchronous, active-low reset (rst==0 resets)
//   start            in   1                  begin a load/init/run sequence; sampled only in IDLE
//   abort            in   1                  synchronous abort, any state -> IDLE
//   run_count        in   CNT_W              number of run pulses; latched on accepted start
//   run_gap          in   GAP_W              idle cycles between run pulses; latched on accepted start
//   cfg_valid        in   1                  config word valid
//   cfg_ready        out  1                  config word accept (high only in LOAD)
//   cfg_data         in   CFG_W              config word; SPM word uses cfg_data[SPM_W-1:0]
//   host_controller  out  SPM_W+ROWS*CFG_W   {spm_cfg, row3, row2, row1, row0}, registered
//   init             out  1                  array init strobe, registered
//   run              out  1                  array run pulse, registered
//   busy             out  1                  high in every state except IDLE
//   done             out  1                  one-cycle pulse at sequence end
// BEHAVIOUR
//   Reset: state=IDLE; host_controller=0; init=run=done=cfg_ready=0; busy=0; all counters 0.
//   States: IDLE, LOAD, INIT, RUN, GAP, DONE. All outputs decoded from registered state (Moore).
//   IDLE: start=1 -> LOAD; latch run_count/run_gap; word index k=0. host_controller holds its last value.
//   LOAD: cfg_ready=1. A word is accepted when cfg_valid&cfg_ready.
//     k<ROWS -> row k buffer gets cfg_data. k==ROWS -> spm_cfg gets cfg_data[SPM_W-1:0].
//     The new value is visible on host_controller the cycle after acceptance. Then k++.
//     Accepting the word with k==ROWS moves to INIT. Words are accepted strictly in order; no skips.
//     cfg_valid=0 stalls indefinitely with no timeout.
//   INIT: init=1 for exactly INIT_CYC consecutive cycles.
//     Then -> RUN if latched run_count!=0, else -> DONE.
//   RUN: run=1 for exactly one cycle; remaining--.
//     If remaining becomes 0 -> DONE.
//     Else if gap==0 -> RUN (back-to-back pulses).
//     Else -> GAP with gap counter = run_gap.
//   GAP: run=0 for exactly run_gap cycles, then -> RUN.
//   DONE: done=1 for one cycle -> IDLE. A start in that cycle is ignored.
//   Total run pulses = run_count. Spacing between pulse rising edges = run_gap+1 cycles.
//   init and run are never high in the same cycle.
//   abort: highest priority. Next cycle state=IDLE; init/run/cfg_ready/busy=0; done is NOT pulsed.
//     host_controller keeps any words already written. A word presented together with abort is not accepted.
//   start outside IDLE is ignored. Changes to run_count/run_gap after latching have no effect.
//   Reset asserted mid-sequence: immediate return to reset values, including host_controller=0.
// TESTING
//   1) Reset values: drive rst=0 mid-RUN -> all outputs 0 asynchronously; after release, state is IDLE.
//   2) Load ordering: start; 5 back-to-back words with cfg_data=k+1.
//      -> row0=1, row1=2, row2=3, row3=4, spm=5. cfg_ready is high 5 cycles; init then goes high.
//   3) Stalled load: cfg_valid toggles 1,0,0,1,... -> only valid cycles advance k.
//      host_controller is unchanged during stalls.
//   4) Run sequencing: run_count=3, run_gap=2 -> init high 3 cycles.
//      Then run pulses at cycles t, t+3, t+6; done one cycle after the last pulse; busy drops with done.
//   5) Edge counts: run_count=0 -> INIT then DONE with no run pulse.
//      run_count=4, run_gap=0 -> run high 4 consecutive cycles.
//   6) Abort: abort during GAP after 1 of 3 pulses -> IDLE next cycle, no done, config retained.
//      A new start reloads and runs correctly.

Source files
------------

// File: rtl/cgra_cfg_sequencer.sv
// Host-side configuration sequencer for the 4x4 CGRA: loads row/SPM config words,
// holds init for a fixed window, then issues a programmed train of run pulses.
module cgra_cfg_sequencer #(
  parameter int CFG_W    = 203,
  parameter int SPM_W    = 20,
  parameter int ROWS     = 4,
  parameter int INIT_CYC = 3,
  parameter int CNT_W    = 16,
  parameter int GAP_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CNT_W-1:0]            run_count,
  input  logic [GAP_W-1:0]            run_gap,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [CFG_W-1:0]            cfg_data,
  output logic [SPM_W+ROWS*CFG_W-1:0] host_controller,
  output logic                        init,
  output logic                        run,
  output logic                        busy,
  output logic                        done
);

  localparam int K_W = $clog2(ROWS + 1);
  localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int I_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [K_W-1:0] K_SPM  = K_W'(ROWS);
  localparam logic [I_W-1:0] I_LAST = I_W'(INIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INIT,
    RUN,
    GAP,
    DONE
  } state_t;

  state_t state, state_n;

  logic [K_W-1:0]   word_idx;
  logic [I_W-1:0]   init_cnt;
  logic [CNT_W-1:0] remaining;
  logic [GAP_W-1:0] gap_len;
  logic [GAP_W-1:0] gap_cnt;
  logic [CFG_W-1:0] row_buf [ROWS];
  logic [SPM_W-1:0] spm_cfg;
  logic             accept;

  // An aborting cycle never consumes the word on the bus.
  assign accept = (state == LOAD) && cfg_valid && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = LOAD;
      LOAD: if (accept && (word_idx == K_SPM)) state_n = INIT;
      INIT: begin
        if (init_cnt == I_LAST) begin
          state_n = (remaining != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (remaining == CNT_W'(1)) begin
          state_n = DONE;
        end else if (gap_len == '0) begin
          state_n = RUN;
        end else begin
          state_n = GAP;
        end
      end
      GAP:     if (gap_cnt == GAP_W'(1)) state_n = RUN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  // Sequencing counters; run parameters are captured only when a start is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_idx  <= '0;
      init_cnt  <= '0;
      remaining <= '0;
      gap_len   <= '0;
      gap_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          init_cnt <= '0;
          if (start) begin
            remaining <= run_count;
            gap_len   <= run_gap;
            word_idx  <= '0;
          end
        end
        LOAD: if (accept) word_idx <= word_idx + 1'b1;
        INIT: init_cnt <= (init_cnt == I_LAST) ? '0 : init_cnt + 1'b1;
        RUN: begin
          remaining <= remaining - 1'b1;
          gap_cnt   <= gap_len;
        end
        GAP:     gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) row_buf[r] <= '0;
      spm_cfg <= '0;
    end else if (accept) begin
      if (word_idx == K_SPM) begin
        spm_cfg <= cfg_data[SPM_W-1:0];
      end else begin
        row_buf[word_idx[R_W-1:0]] <= cfg_data;
      end
    end
  end

  // Strobes are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_ready <= 1'b0;
      init      <= 1'b0;
      run       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cfg_ready <= (state_n == LOAD);
      init      <= (state_n == INIT);
      run       <= (state_n == RUN);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign host_controller[r*CFG_W +: CFG_W] = row_buf[r];
  end
  assign host_controller[ROWS*CFG_W +: SPM_W] = spm_cfg;

endmodule

// File: tb/tb_cgra_cfg_sequencer.sv
// Randomized bench for cgra_cfg_sequencer: expected control waveform is built as a
// per-cycle timeline from the load/init/run rules and compared cycle by cycle.
module tb_cgra_cfg_sequencer;

  localparam int CFG_W    = 203;
  localparam int SPM_W    = 20;
  localparam int ROWS     = 4;
  localparam int INIT_CYC = 3;
  localparam int CNT_W    = 16;
  localparam int GAP_W    = 8;
  localparam int HC_W     = SPM_W + ROWS*CFG_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] run_count = '0;
  logic [GAP_W-1:0] run_gap = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CFG_W-1:0] cfg_data = '0;
  logic [HC_W-1:0]  host_controller;
  logic             init, run, busy, done;

  logic [HC_W-1:0]  hc_model = '0;
  int checks = 0;
  int failures = 0;

  cgra_cfg_sequencer #(
    .CFG_W(CFG_W), .SPM_W(SPM_W), .ROWS(ROWS),
    .INIT_CYC(INIT_CYC), .CNT_W(CNT_W), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .run_count(run_count), .run_gap(run_gap),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .host_controller(host_controller),
    .init(init), .run(run), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [HC_W-1:0] got, input logic [HC_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full start/load/init/run sequence. abort_load: word index at which abort hits LOAD;
  // abort_tl / reset_tl: position in the post-load timeline where abort / reset is applied (-1 = never).
  task automatic applyStimulus(input int count, input int gap, input int valid_pct,
                               input int abort_load, input int abort_tl, input int reset_tl);
    logic [2:0]   exp_q[$];
    logic [223:0] wide;
    int k;
    int guard;
    @(negedge clk);
    checkOutput("idle_busy", HC_W'(busy), HC_W'(1'b0));
    start = 1'b1;
    run_count = CNT_W'(count);
    run_gap = GAP_W'(gap);
    @(negedge clk);
    start = 1'b0;
    run_count = CNT_W'($urandom);
    run_gap = GAP_W'($urandom);
    k = 0;
    guard = 0;
    while (k <= ROWS) begin
      checkOutput("load_ready", HC_W'(cfg_ready), HC_W'(1'b1));
      checkOutput("load_busy", HC_W'(busy), HC_W'(1'b1));
      checkOutput("load_hc", host_controller, hc_model);
      wide = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cfg_data = wide[CFG_W-1:0];
      cfg_valid = ($urandom_range(99) < valid_pct);
      if (abort_load == k) begin
        cfg_valid = 1'b1;
        abort = 1'b1;
      end
      @(negedge clk);
      if (abort) begin
        abort = 1'b0;
        cfg_valid = 1'b0;
        checkOutput("abort_load_ctrl", HC_W'({busy, cfg_ready, init, run, done}), HC_W'(5'b0));
        checkOutput("abort_load_hc", host_controller, hc_model);
        return;
      end
      if (cfg_valid) begin
        if (k < ROWS) hc_model[k*CFG_W +: CFG_W] = cfg_data;
        else hc_model[ROWS*CFG_W +: SPM_W] = cfg_data[SPM_W-1:0];
        k++;
      end
      guard++;
      if (guard >= 500) begin
        checkOutput("load_timeout", HC_W'(k), HC_W'(ROWS + 1));
        cfg_valid = 1'b0;
        return;
      end
    end
    cfg_valid = 1'b0;

    // Expected {init,run,done} per cycle after the final word is taken.
    for (int i = 0; i < INIT_CYC; i++) exp_q.push_back(3'b100);
    for (int p = 0; p < count; p++) begin
      exp_q.push_back(3'b010);
      if (p < count - 1) for (int g = 0; g < gap; g++) exp_q.push_back(3'b000);
    end
    exp_q.push_back(3'b001);

    for (int i = 0; i < exp_q.size(); i++) begin
      checkOutput("tl_ctrl", HC_W'({init, run, done}), HC_W'(exp_q[i]));
      checkOutput("tl_busy", HC_W'({busy, cfg_ready}), HC_W'(2'b10));
      checkOutput("tl_hc", host_controller, hc_model);
      if (i == reset_tl) begin
        start = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("rst_ctrl", HC_W'({busy, cfg_ready, init, run, done}), HC_W'(5'b0));
        checkOutput("rst_hc", host_controller, HC_W'(0));
        hc_model = '0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (i == abort_tl) begin
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_ctrl", HC_W'({busy, cfg_ready, init, run, done}), HC_W'(5'b0));
        checkOutput("abort_hc", host_controller, hc_model);
        repeat (3) begin
          @(negedge clk);
          checkOutput("abort_quiet", HC_W'({busy, run, done}), HC_W'(3'b0));
        end
        return;
      end
      start = ($urandom_range(3) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("end_idle", HC_W'({busy, cfg_ready, init, run, done}), HC_W'(5'b0));
    checkOutput("end_hc", host_controller, hc_model);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", HC_W'({busy, cfg_ready, init, run, done}), HC_W'(5'b0));
    checkOutput("reset_hc", host_controller, HC_W'(0));
    rst = 1'b1;

    applyStimulus(3, 2, 100, -1, -1, -1);
    applyStimulus(3, 2, 50, -1, -1, -1);
    applyStimulus(0, 1, 100, -1, -1, -1);
    applyStimulus(4, 0, 100, -1, -1, -1);
    applyStimulus(3, 3, 60, -1, INIT_CYC + 1, -1);
    applyStimulus(2, 1, 100, -1, -1, -1);
    applyStimulus(3, 1, 100, -1, -1, INIT_CYC);
    applyStimulus(1, 0, 100, -1, -1, -1);
    applyStimulus(2, 2, 80, 2, -1, -1);
    applyStimulus(2, 0, 100, -1, -1, -1);
    for (int n = 0; n < 25; n++) begin
      applyStimulus($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(30, 100), -1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
